mult_arbiter: RTL and testbench

MULT_ARBITER -- requirements
Module: mult_arbiter

---
 rtl/mult_arbiter.sv | 133 +++++++++++++
 tb/tb_mult_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mult_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mult_arbiter
//  Description : Two-client round-robin arbiter in front of a shared
//                shift-and-add unsigned multiplier. One operation runs at a
//                time and takes a fixed WIDTH iterations.
//  Revision    : 1.0  initial release
// ============================================================================
module mult_arbiter #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req0,
   input  logic                 req1,
   input  logic [WIDTH-1:0]     a0,
   input  logic [WIDTH-1:0]     b0,
   input  logic [WIDTH-1:0]     a1,
   input  logic [WIDTH-1:0]     b1,
   output logic                 ack0,
   output logic                 ack1,
   output logic                 done0,
   output logic                 done1,
   output logic [2*WIDTH-1:0]   product,
   output logic                 busy
);

   localparam int             CW          = $clog2(WIDTH + 1);
   localparam logic [1:0]     c_ST_IDLE   = 2'd0;
   localparam logic [1:0]     c_ST_BUSY   = 2'd1;
   localparam logic [1:0]     c_ST_DONE   = 2'd2;
   localparam logic [CW-1:0]  c_CNT_LAST  = CW'(WIDTH - 1);
   localparam logic [CW-1:0]  c_CNT_ONE   = CW'(1);

   logic [1:0]          r_state;
   logic [1:0]          w_state_nxt;
   logic                r_client;     // client owning the current operation
   logic                r_last;       // client granted most recently
   logic [WIDTH-1:0]    r_mplier;
   logic [2*WIDTH-1:0]  r_mcand;
   logic [2*WIDTH-1:0]  r_acc;
   logic [2*WIDTH-1:0]  r_product;
   logic [CW-1:0]       r_cnt;

   logic                w_req_any;
   logic                w_gnt_sel;
   logic                w_last_step;
   logic [2*WIDTH-1:0]  w_sum;

   assign w_req_any   = req0 | req1;
   // A lone requester wins; on a tie the client not served last wins.
   assign w_gnt_sel   = (req0 & req1) ? ~r_last : req1;
   assign w_last_step = (r_cnt == c_CNT_LAST);
   assign w_sum       = r_acc + (r_mplier[0] ? r_mcand : '0);

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= c_ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode; unused encodings fall back to IDLE.
   always_comb begin
      w_state_nxt = c_ST_IDLE;
      case (r_state)
         c_ST_IDLE: w_state_nxt = w_req_any ? c_ST_BUSY : c_ST_IDLE;
         c_ST_BUSY: w_state_nxt = w_last_step ? c_ST_DONE : c_ST_BUSY;
         c_ST_DONE: w_state_nxt = c_ST_IDLE;
         default:   w_state_nxt = c_ST_IDLE;
      endcase
   end

   // Output decode: ack on the first BUSY cycle, done during DONE.
   always_comb begin
      busy  = (r_state != c_ST_IDLE);
      ack0  = 1'b0;
      ack1  = 1'b0;
      done0 = 1'b0;
      done1 = 1'b0;
      if (r_state == c_ST_BUSY && r_cnt == '0) begin
         ack0 = ~r_client;
         ack1 =  r_client;
      end
      if (r_state == c_ST_DONE) begin
         done0 = ~r_client;
         done1 =  r_client;
      end
   end

   // Grant capture and fixed-length shift-and-add datapath.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_client  <= 1'b0;
         r_last    <= 1'b1;
         r_mplier  <= '0;
         r_mcand   <= '0;
         r_acc     <= '0;
         r_product <= '0;
         r_cnt     <= '0;
      end else begin
         case (r_state)
            c_ST_IDLE: begin
               if (w_req_any) begin
                  r_client <= w_gnt_sel;
                  r_last   <= w_gnt_sel;
                  r_mplier <= w_gnt_sel ? a1 : a0;
                  r_mcand  <= {{WIDTH{1'b0}}, (w_gnt_sel ? b1 : b0)};
                  r_acc    <= '0;
                  r_cnt    <= '0;
               end
            end
            c_ST_BUSY: begin
               r_acc    <= w_sum;
               r_mcand  <= r_mcand << 1;
               r_mplier <= r_mplier >> 1;
               r_cnt    <= r_cnt + c_CNT_ONE;
               if (w_last_step) begin
                  r_product <= w_sum;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign product = r_product;

endmodule
`default_nettype wire

// File: tb/tb_mult_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mult_arbiter
//  Description : Self-checking bench for mult_arbiter (WIDTH=8). Expected
//                products are queued when a request is driven and compared
//                when the matching done pulse appears.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mult_arbiter;

   localparam int WIDTH = 8;

   typedef struct { int cl; int a; int b; int exp; } vec_t;
   typedef struct { int cl; int prod; } sb_t;

   logic               clk = 1'b0;
   logic               rst;
   logic               req0, req1;
   logic [WIDTH-1:0]   a0, b0, a1, b1;
   logic               ack0, ack1, done0, done1, busy;
   logic [2*WIDTH-1:0] product;

   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   int   ack_cyc = 0;
   int   done_cyc = 0;
   int   n_ack   = 0;
   int   busy_run = 0;
   bit   abort   = 1'b0;
   sb_t  sbq[$];

   mult_arbiter #(.WIDTH(WIDTH)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .req1(req1),
      .a0(a0), .b0(b0), .a1(a1), .b1(b1),
      .ack0(ack0), .ack1(ack1), .done0(done0), .done1(done1),
      .product(product), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pulse exclusivity, scoreboard pop on done, busy length.
   always @(posedge clk) begin
      sb_t e;
      #1;
      cyc++;
      if (ack0 | ack1 | done0 | done1)
         chk("pulse_excl", $countones({ack0, ack1, done0, done1}), 1);
      if (ack0 | ack1) begin
         n_ack++;
         ack_cyc = cyc;
      end
      if (done0 | done1) begin
         if (sbq.size() == 0) begin
            chk("spurious_done", 1, 0);
         end else begin
            e = sbq.pop_front();
            chk("done_client", {31'b0, done1}, e.cl);
            chk("product", {16'b0, product}, e.prod);
            chk("ack_to_done", cyc - ack_cyc, WIDTH);
         end
         done_cyc = cyc;
      end
      if (busy) begin
         busy_run++;
      end else begin
         if (busy_run != 0 && !abort) chk("busy_len", busy_run, WIDTH + 1);
         busy_run = 0;
      end
   end

   task automatic wait_ack(input int cl, output int lat);
      bit got = 1'b0;
      lat = 0;
      while (!got && lat < 20) begin
         @(posedge clk); #2;
         lat++;
         got = (cl == 0) ? ack0 : ack1;
      end
      if (!got) lat = 99;
   endtask

   task automatic wait_done(input int cl);
      bit got = 1'b0;
      int n = 0;
      while (!got && n < 30) begin
         @(posedge clk); #2;
         n++;
         got = (cl == 0) ? done0 : done1;
      end
      if (!got) chk("done_timeout", 0, 1);
      @(posedge clk); #2;   // back in IDLE
   endtask

   task automatic op(input int cl, input int a, input int b, input int exp);
      int lat;
      sbq.push_back('{cl, exp});
      if (cl == 0) begin a0 = a[7:0]; b0 = b[7:0]; req0 = 1'b1; end
      else         begin a1 = a[7:0]; b1 = b[7:0]; req1 = 1'b1; end
      wait_ack(cl, lat);
      chk("ack_latency", lat, 1);
      req0 = 1'b0; req1 = 1'b0;
      a0 = 8'($urandom); b0 = 8'($urandom);
      a1 = 8'($urandom); b1 = 8'($urandom);
      wait_done(cl);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t vecs[7];
      int   lat, cnt, n, n0, d0;

      vecs[0] = '{0,  13,  11,   143};
      vecs[1] = '{1, 255, 255, 65025};
      vecs[2] = '{0,   0, 200,     0};
      vecs[3] = '{1,   1, 255,   255};
      vecs[4] = '{0, 255,   1,   255};
      vecs[5] = '{1, 128,   2,   256};
      vecs[6] = '{0, 170,  85, 14450};

      rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
      a0 = '0; b0 = '0; a1 = '0; b1 = '0;
      repeat (3) @(posedge clk);
      #2;
      chk("rst_busy", busy, 0);
      chk("rst_product", product, 0);
      chk("rst_pulses", {ack0, ack1, done0, done1}, 0);
      rst = 1'b1;
      @(posedge clk); #2;
      chk("idle_no_req", busy, 0);

      // Tie straight after reset: client 0 first, one IDLE cycle, then client 1.
      a0 = 8'd20; b0 = 8'd30; a1 = 8'd40; b1 = 8'd50;
      sbq.push_back('{0, 600});
      sbq.push_back('{1, 2000});
      req0 = 1'b1; req1 = 1'b1;
      wait_ack(0, lat);
      chk("tie_first_ack0", lat, 1);
      req0 = 1'b0;
      wait_ack(1, lat);
      chk("tie_ack1_found", {31'b0, lat != 99}, 1);
      chk("tie_idle_gap", cyc - done_cyc, 2);
      req1 = 1'b0;
      wait_done(1);

      // Fairness: both held high, grants must alternate 0,1,0,1.
      a0 = 8'd3; b0 = 8'd5; a1 = 8'd9; b1 = 8'd7;
      sbq.push_back('{0, 15});
      sbq.push_back('{1, 63});
      sbq.push_back('{0, 15});
      sbq.push_back('{1, 63});
      req0 = 1'b1; req1 = 1'b1;
      cnt = 0; n = 0;
      while (cnt < 4 && n < 80) begin
         @(posedge clk); #2;
         n++;
         if (ack0 | ack1) cnt++;
      end
      req0 = 1'b0; req1 = 1'b0;
      chk("fair_grants", cnt, 4);
      n = 0;
      while (sbq.size() != 0 && n < 40) begin
         @(posedge clk); #2;
         n++;
      end
      chk("fair_drain", sbq.size(), 0);
      @(posedge clk); #2;

      // Table of single operations, including the operand extremes.
      for (int i = 0; i < 7; i++) op(vecs[i].cl, vecs[i].a, vecs[i].b, vecs[i].exp);

      // Stability: operands and req1 wiggle during BUSY.
      sbq.push_back('{0, 120});
      a0 = 8'd12; b0 = 8'd10; req0 = 1'b1;
      wait_ack(0, lat);
      chk("stab_ack", lat, 1);
      n0 = n_ack;
      req0 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #2;
         req1 = ~req1;
         a0 = 8'($urandom); b0 = 8'($urandom);
         a1 = 8'($urandom); b1 = 8'($urandom);
      end
      req1 = 1'b0;
      wait_done(0);
      d0 = n_ack - n0;
      chk("stab_extra_ack", d0, 0);

      // Reset on the 4th BUSY cycle aborts with no done pulse.
      a0 = 8'd100; b0 = 8'd100; req0 = 1'b1;
      wait_ack(0, lat);
      req0 = 1'b0;
      repeat (3) begin @(posedge clk); #2; end
      abort = 1'b1;
      rst = 1'b0;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_product", product, 0);
      chk("abort_pulses", {ack0, ack1, done0, done1}, 0);
      repeat (3) begin @(posedge clk); #2; end
      rst = 1'b1;
      repeat (2) begin @(posedge clk); #2; end
      chk("abort_idle", busy, 0);
      abort = 1'b0;
      op(1, 7, 6, 42);

      repeat (5) @(posedge clk);
      #2;
      chk("sb_empty", sbq.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
